// File: rtl/serial_slice_adder_ctrl_if.sv
// Request/response bundle for the serial slice adder sequencer.
//
// Handshake: a request transfers on a rising clk edge where start_valid and
// start_ready are both high; a response transfers on an edge where res_valid
// and res_ready are both high. A valid holds until the matching transfer.
// Payload is sampled at the transfer edge. Readiness never depends
// combinationally on the partner's valid.
interface serial_slice_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             carry_in;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic [1:0]       dbg_state;

  // Producer/consumer side.
  modport master (
    output start_valid, op_a, op_b, sub, carry_in, res_ready,
    input  start_ready, res_valid, sum, carry_out, overflow, busy, dbg_state
  );

  // Sequencer side.
  modport slave (
    input  start_valid, op_a, op_b, sub, carry_in, res_ready,
    output start_ready, res_valid, sum, carry_out, overflow, busy, dbg_state
  );
endinterface

// File: rtl/serial_slice_adder_ctrl.sv
// WIDTH-bit add/subtract built from one SLICE-bit ripple-carry slice reused
// over NSLICE cycles, with the inter-slice carry kept in a register.
// WIDTH must be an integer multiple of SLICE.
module serial_slice_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_slice_adder_ctrl_if.slave   bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic             cy;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             ov_r;

  logic             last;
  int unsigned      base;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE:0]   s;
  logic             c_msb;

  // Slice datapath: one SLICE-bit ripple add of the selected operand bits.
  always_comb begin
    last  = (idx == IW'(NSLICE - 1));
    base  = int'(idx) * SLICE;
    a_s   = a_r[base +: SLICE];
    b_s   = b_r[base +: SLICE];
    s     = {1'b0, a_s} + {1'b0, b_s} + {{SLICE{1'b0}}, cy};
    // Carry into the slice's top bit; on the final slice this is the carry
    // into bit WIDTH-1, needed for signed overflow.
    c_msb = a_s[SLICE-1] ^ b_s[SLICE-1] ^ s[SLICE-1];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start_valid) state_next = RUN;
      RUN:     if (last)            state_next = DONE;
      DONE:    if (bus.res_ready)   state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // Operand capture, per-slice result write-back and final flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx   <= '0;
      cy    <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      co_r  <= 1'b0;
      ov_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            // Subtract is A + ~B + 1, so the slice only ever adds.
            a_r <= bus.op_a;
            b_r <= bus.sub ? ~bus.op_b : bus.op_b;
            cy  <= bus.sub ? 1'b1 : bus.carry_in;
            idx <= '0;
          end
        end
        RUN: begin
          sum_r[base +: SLICE] <= s[SLICE-1:0];
          cy                   <= s[SLICE];
          if (last) begin
            co_r <= s[SLICE];
            ov_r <= c_msb ^ s[SLICE];
            idx  <= '0;
          end else begin
            idx  <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decoded from registered state only.
  assign bus.start_ready = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.sum         = sum_r;
  assign bus.carry_out   = co_r;
  assign bus.overflow    = ov_r;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_serial_slice_adder_ctrl.sv
// Bench for serial_slice_adder_ctrl: directed test-plan vectors, randomized
// operations against an arithmetic reference, backpressure and mid-run reset.
module tb_serial_slice_adder_ctrl;
  localparam int W  = 16;
  localparam int NS = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  serial_slice_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_slice_adder_ctrl #(.WIDTH(W), .SLICE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width arithmetic, flags from sign rules.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sb, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ov;
    bb   = sb ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + ((sb ? 1'b1 : cin) ? 17'd1 : 17'd0);
    ov   = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  // Driver: issue one request, wait for res_valid; DUT is left in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sb, input logic cin,
                        output logic [W-1:0] s, output logic co, output logic ov,
                        output int lat, output bit ok);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.start_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.op_a = a; bus.op_b = b; bus.sub = sb; bus.carry_in = cin;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    lat = 0;
    while (!bus.res_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ok = bus.res_valid && (guard < 50);
    s = bus.sum; co = bus.carry_out; ov = bus.overflow;
  endtask

  // Driver: accept the pending response.
  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.start_ready !== 1'b1) begin failures++; $display("FAIL reset_start_ready got=%b exp=1", bus.start_ready); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", bus.sum); end
    checks++; if (bus.carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry_out got=%b exp=0", bus.carry_out); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [7] = '{16'h00FF, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h0005, 16'h8000, 16'h1234};
    logic [W-1:0] tb [7] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h1111};
    logic         tsb[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic         tci[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] es [7] = '{16'h0100, 16'h0000, 16'h0003, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h2345};
    logic         eco[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         eov[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit ok;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], tsb[i], tci[i], s, co, ov, lat, ok);
      checks++; if (!ok || lat != NS) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NS); end
      checks++; if (s !== es[i]) begin failures++; $display("FAIL dir%0d_sum got=%h exp=%h", i, s, es[i]); end
      checks++; if (co !== eco[i]) begin failures++; $display("FAIL dir%0d_carry_out got=%b exp=%b", i, co, eco[i]); end
      checks++; if (ov !== eov[i]) begin failures++; $display("FAIL dir%0d_overflow got=%b exp=%b", i, ov, eov[i]); end
      consume();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic sb, cin, co, ov;
    logic [W+1:0] e;
    int lat;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      sb = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      e = model(a, b, sb, cin);
      run_op(a, b, sb, cin, s, co, ov, lat, ok);
      checks++;
      if (!ok || lat != NS || s !== e[W-1:0] || co !== e[W] || ov !== e[W+1]) begin
        failures++;
        $display("FAIL rand%0d a=%h b=%h sub=%b cin=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=%0d",
                 i, a, b, sb, cin, s, co, ov, lat, e[W-1:0], e[W], e[W+1], NS);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s;
    logic co, ov;
    logic [W+1:0] e;
    int lat;
    bit ok;
    int bad;
    e = model(16'h8000, 16'h0001, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, s, co, ov, lat, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_result_timeout got=none exp=res_valid"); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      bus.start_valid = ~bus.start_valid;
      bus.op_a = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (bus.sum !== e[W-1:0] || bus.carry_out !== e[W] || bus.overflow !== e[W+1] ||
          bus.start_ready !== 1'b0 || bus.busy !== 1'b1 || bus.res_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got=%h/%b/%b sr=%b busy=%b rv=%b exp=%h/%b/%b sr=0 busy=1 rv=1",
                 i, bus.sum, bus.carry_out, bus.overflow, bus.start_ready, bus.busy, bus.res_valid,
                 e[W-1:0], e[W], e[W+1]);
      end
    end
    checks++; if (bad != 0) failures++;
    bus.start_valid = 1'b0;
    consume();
    checks++; if (bus.start_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release got sr=%b rv=%b exp sr=1 rv=0", bus.start_ready, bus.res_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit ok;
    int seen;
    @(negedge clk);
    bus.op_a = 16'hFFFF; bus.op_b = 16'hFFFF; bus.sub = 1'b0; bus.carry_in = 1'b1;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1 || bus.sum !== 16'h0000) begin
      failures++; $display("FAIL midrst_state got busy=%b sr=%b sum=%h exp busy=0 sr=1 sum=0000",
                           bus.busy, bus.start_ready, bus.sum);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, s, co, ov, lat, ok);
    checks++; if (!ok || s !== 16'h2345 || co !== 1'b0 || lat != NS) begin
      failures++; $display("FAIL midrst_next got=%h/%b lat=%0d exp=2345/0 lat=%0d", s, co, lat, NS);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic co, ov;
    logic [W+1:0] e;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      e = model(16'h4000 + W'(i), 16'h4000, 1'b0, 1'b0);
      run_op(16'h4000 + W'(i), 16'h4000, 1'b0, 1'b0, s, co, ov, lat, ok);
      checks++; if (!ok || s !== e[W-1:0] || ov !== e[W+1]) begin
        failures++; $display("FAIL b2b%0d got=%h/%b exp=%h/%b", i, s, ov, e[W-1:0], e[W+1]);
      end
      consume();
    end
  endtask

  // Sequence of scenarios and final report.
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1;
    bus.start_valid = 1'b0; bus.res_ready = 1'b0;
    bus.op_a = '0; bus.op_b = '0; bus.sub = 1'b0; bus.carry_in = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
